// File: rtl/mdu_issue_if.sv
// EX-to-WB handshake bundle around the MDU issue stage: op request from EX, result return to WB.
interface mdu_issue_if;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_op;
    logic        in_word;
    logic [63:0] in_src1;
    logic [63:0] in_src2;
    logic [4:0]  in_rd;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_result;
    logic [4:0]  out_rd;
    logic        out_illegal;

    modport master (
        output in_valid, in_op, in_word, in_src1, in_src2, in_rd, out_ready,
        input  in_ready, out_valid, out_result, out_rd, out_illegal
    );

    modport slave (
        input  in_valid, in_op, in_word, in_src1, in_src2, in_rd, out_ready,
        output in_ready, out_valid, out_result, out_rd, out_illegal
    );
endinterface

// File: rtl/mdu_issue.sv
// Issue/sequencing stage for the combinational RV64M core: decodes funct3, prepares W operands,
// holds them for LATENCY cycles, then returns the (sign-extended) result with its rd tag.
module mdu_issue #(
    parameter int LATENCY = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    mdu_issue_if.slave  io,
    output logic        mdu_mul,
    output logic        mdu_mulh,
    output logic        mdu_mulhsu,
    output logic        mdu_mulhu,
    output logic        mdu_div,
    output logic        mdu_divu,
    output logic        mdu_rem,
    output logic        mdu_remu,
    output logic [63:0] mdu_src1,
    output logic [63:0] mdu_src2,
    input  logic [63:0] mdu_result
);
    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    localparam logic [2:0] OP_MULH   = 3'd1;
    localparam logic [2:0] OP_MULHSU = 3'd2;
    localparam logic [2:0] OP_MULHU  = 3'd3;
    localparam logic [2:0] OP_DIVU   = 3'd5;
    localparam logic [2:0] OP_REMU   = 3'd7;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic               accept, capture;
    logic [7:0]         ctl;

    logic [2:0]         op_p1;
    logic               word_p1, illegal_p1;
    logic [4:0]         rd_p1;
    logic [63:0]        src1_p1, src2_p1;

    logic signed [63:0] result_p2;
    logic [4:0]         rd_p2;
    logic               illegal_p2;

    // Unsigned W divides see a zero-extended word; every other W op sees it sign-extended.
    function automatic logic [63:0] prep_operand(input logic [2:0] op, input logic word,
                                                 input logic [63:0] s);
        if (!word)
            return s;
        if (op == OP_DIVU || op == OP_REMU)
            return {32'b0, s[31:0]};
        return {{32{s[31]}}, s[31:0]};
    endfunction

    function automatic logic signed [63:0] sext_word(input logic signed [31:0] r);
        return {{32{r[31]}}, r};
    endfunction

    function automatic logic is_illegal(input logic [2:0] op, input logic word);
        return word && (op == OP_MULH || op == OP_MULHSU || op == OP_MULHU);
    endfunction

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        capture     = 1'b0;
        io.in_ready = (state == IDLE) && !flush;
        accept      = io.in_valid && io.in_ready;
        unique case (state)
            IDLE: if (accept) begin
                state_nxt = BUSY;
                cnt_nxt   = CNT_W'(LATENCY - 1);
            end
            BUSY: if (cnt == '0) begin
                capture   = 1'b1;
                state_nxt = DONE;
            end else begin
                cnt_nxt = cnt - CNT_W'(1);
            end
            DONE: if (io.out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        // A kill wins over everything, including a capture on the same edge.
        if (flush) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
            capture   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // p1: latched op and prepared operands, held for the whole BUSY window
    // p2: captured result returned to WB
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_p1      <= '0;
            word_p1    <= 1'b0;
            illegal_p1 <= 1'b0;
            rd_p1      <= '0;
            src1_p1    <= '0;
            src2_p1    <= '0;
            result_p2  <= '0;
            rd_p2      <= '0;
            illegal_p2 <= 1'b0;
        end else begin
            if (accept) begin
                op_p1      <= io.in_op;
                word_p1    <= io.in_word;
                illegal_p1 <= is_illegal(io.in_op, io.in_word);
                rd_p1      <= io.in_rd;
                src1_p1    <= prep_operand(io.in_op, io.in_word, io.in_src1);
                src2_p1    <= prep_operand(io.in_op, io.in_word, io.in_src2);
            end
            if (capture) begin
                if (illegal_p1)
                    result_p2 <= '0;
                else if (word_p1)
                    result_p2 <= sext_word(mdu_result[31:0]);
                else
                    result_p2 <= mdu_result;
                rd_p2      <= rd_p1;
                illegal_p2 <= illegal_p1;
            end
        end
    end

    always_comb begin
        ctl = '0;
        if (state == BUSY && !illegal_p1)
            ctl[op_p1] = 1'b1;
    end

    assign {mdu_remu, mdu_rem, mdu_divu, mdu_div,
            mdu_mulhu, mdu_mulhsu, mdu_mulh, mdu_mul} = ctl;
    assign mdu_src1       = src1_p1;
    assign mdu_src2       = src2_p1;
    assign io.out_valid   = (state == DONE);
    assign io.out_result  = result_p2;
    assign io.out_rd      = rd_p2;
    assign io.out_illegal = illegal_p2;
endmodule
